// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   op_e    - M-extension operation encodings (MUL=0 .. REMU=7)
//   state_e - sequencer states (IDLE, RUN, FIX)
//   helpers - is_div, is_rem, is_signed_a, is_signed_b
package alu_muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  function automatic logic is_div(input op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_rem(input op_e op);
    return op inside {REM, REMU};
  endfunction

  // MUL only uses the low half, which is sign-agnostic, but treating it as
  // signed keeps the sign bookkeeping identical to MULH.
  function automatic logic is_signed_a(input op_e op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_addsub_nbit.sv
// muldiv_addsub_nbit
// W-bit adder/subtractor with carry-out, shared by the multiply (add) and
// divide (subtract) iteration steps.
//   x, y       in  W  operands
//   sub        in  1  1: x - y, 0: x + y
//   sum        out W  result
//   carry_out  out 1  carry; for subtraction it is 1 exactly when x >= y
module muldiv_addsub_nbit #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  logic [W-1:0] y_eff;

  assign y_eff = sub ? ~y : y;
  assign {carry_out, sum} = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/alu_muldiv_nbit.sv
// alu_muldiv_nbit
// Iterative RV32M multiply/divide unit. One operation at a time through a
// start/done handshake; N shift-add or restoring subtract-shift steps on a
// shared N+1-bit adder, then one fix-up cycle for sign and half selection.
// Optional feature macro: ALU_MULDIV_DIV_EN (divider hardware present). With
// it undefined, every divide/remainder op finishes in one cycle as all-ones.
// Ports:
//   clk     in  1  rising-edge clock
//   rst_n   in  1  synchronous active-low reset
//   start   in  1  operation request (taken in IDLE, or in FIX when not flushed)
//   op      in  3  op_e encoding
//   a, b    in  N  rs1 / rs2 operands
//   flush   in  1  abort; wins over start
//   busy    out 1  operation in progress
//   done    out 1  one-cycle result-valid pulse
//   result  out N  last result, held until replaced
module alu_muldiv_nbit
  import alu_muldiv_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam logic [N-1:0]     MIN_NEG   = {1'b1, {(N-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N-1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  op_e                op_q;
  logic               neg_q, special_q;
  logic [N-1:0]       hi_q, lo_q, opnd_q, result_q;

  op_e                op_in;
  logic               accept;
  logic               a_neg, b_neg, neg_in;
  logic [N-1:0]       a_mag, b_mag;
  logic               special_in;
  logic [N-1:0]       special_val;
  logic [N-1:0]       fix_val;
  logic [2*N-1:0]     prod, prod_fix;

  logic [N:0]         add_x, add_y, add_sum;
  logic               add_sub, add_cout;

`ifdef ALU_MULDIV_DIV_EN
  logic [N:0]         rem_q;
  logic [N:0]         shifted;
  logic               unused_rem_msb;

  // The stored remainder is always below the divisor, so its top bit stays 0;
  // the N+1-bit width matters only once it is shifted onto the adder input.
  assign shifted        = {rem_q[N-1:0], lo_q[N-1]};
  assign unused_rem_msb = rem_q[N];
`else
  logic               unused_cout;

  assign unused_cout = add_cout;
`endif

  assign op_in  = op_e'(op);
  assign a_neg  = is_signed_a(op_in) & a[N-1];
  assign b_neg  = is_signed_b(op_in) & b[N-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign neg_in = is_rem(op_in) ? a_neg : (a_neg ^ b_neg);

  // Cases settled without iterating; the result is preloaded into lo_q.
  always_comb begin
    special_in  = 1'b0;
    special_val = '1;
    if (is_div(op_in)) begin
`ifdef ALU_MULDIV_DIV_EN
      if (b == '0) begin
        special_in  = 1'b1;
        special_val = is_rem(op_in) ? a : '1;
      end else if (is_signed_a(op_in) && (a == MIN_NEG) && (b == '1)) begin
        special_in  = 1'b1;
        special_val = is_rem(op_in) ? '0 : a;
      end
`else
      special_in  = 1'b1;
      special_val = '1;
`endif
    end
  end

  // Adder operand steering: multiply adds the multiplicand when the current
  // multiplier bit is set; divide trial-subtracts the divisor.
  always_comb begin
    add_x   = {1'b0, hi_q};
    add_y   = lo_q[0] ? {1'b0, opnd_q} : '0;
    add_sub = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
    if (is_div(op_q)) begin
      add_x   = shifted;
      add_y   = {1'b0, opnd_q};
      add_sub = 1'b1;
    end
`endif
  end

  muldiv_addsub_nbit #(.W(N+1)) u_addsub (
    .x         (add_x),
    .y         (add_y),
    .sub       (add_sub),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  // Final sign correction and half / quotient-remainder selection.
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    fix_val  = (op_q == MUL) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
`ifdef ALU_MULDIV_DIV_EN
    if (is_div(op_q)) begin
      if (is_rem(op_q)) fix_val = neg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
      else              fix_val = neg_q ? -lo_q : lo_q;
    end
`endif
    if (special_q) fix_val = lo_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FIX hands straight back to a new start so back-to-back ops have no bubble.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    result  = result_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          accept  = 1'b1;
          state_d = special_in ? FIX : RUN;
        end
      end
      RUN: begin
        if (flush)                   state_d = IDLE;
        else if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          done   = 1'b1;
          result = fix_val;
          if (start) begin
            accept  = 1'b1;
            state_d = special_in ? FIX : RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= MUL;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
`ifdef ALU_MULDIV_DIV_EN
      rem_q     <= '0;
`endif
    end else begin
      if (done) result_q <= fix_val;
      if (flush) begin
        cnt_q <= '0;
      end else if (accept) begin
        op_q      <= op_in;
        neg_q     <= neg_in;
        special_q <= special_in;
        cnt_q     <= '0;
        hi_q      <= '0;
`ifdef ALU_MULDIV_DIV_EN
        rem_q     <= '0;
`endif
        if (special_in) begin
          lo_q <= special_val;
        end else if (is_div(op_in)) begin
          lo_q   <= a_mag;
          opnd_q <= b_mag;
        end else begin
          lo_q   <= b_mag;
          opnd_q <= a_mag;
        end
      end else if (state_q == RUN) begin
        cnt_q <= (cnt_q == LAST_STEP) ? '0 : cnt_q + CNT_W'(1);
`ifdef ALU_MULDIV_DIV_EN
        if (is_div(op_q)) begin
          rem_q <= add_cout ? add_sum : shifted;
          lo_q  <= {lo_q[N-2:0], add_cout};
        end else
`endif
        begin
          // Product shifts right one bit per step; the adder carry becomes
          // the new top bit of the high half.
          hi_q <= add_sum[N:1];
          lo_q <= {add_sum[0], lo_q[N-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_nbit.sv
// tb_alu_muldiv_nbit
// Directed and randomised bench for alu_muldiv_nbit (N=32). Expected results
// and latencies are queued when an operation is started and popped when done
// is seen. Divide expectations follow ALU_MULDIV_DIV_EN.
module tb_alu_muldiv_nbit;
  import alu_muldiv_pkg::*;

`ifdef ALU_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] last_result;
  int          n_vec  = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  alu_muldiv_nbit #(.N(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  function automatic logic [31:0] ref_model(input op_e o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, ps;
    logic [63:0]        ux, uy, pu;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    pu = ux * uy;
    case (o)
      MUL:    return pu[31:0];
      MULH:   begin ps = sx * sy;          return ps[63:32]; end
      MULHSU: begin ps = sx * $signed(uy); return ps[63:32]; end
      MULHU:  return pu[63:32];
      default: begin
        if (!DIV_EN) return 32'hFFFF_FFFF;
        if (y == 32'd0) return (o == REM || o == REMU) ? x : 32'hFFFF_FFFF;
        if ((o == DIV || o == REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return (o == DIV) ? x : 32'd0;
        case (o)
          DIV:     return $signed(x) / $signed(y);
          DIVU:    return x / y;
          REM:     return $signed(x) % $signed(y);
          default: return x % y;
        endcase
      end
    endcase
  endfunction

  function automatic int ref_latency(input op_e o, input logic [31:0] x, input logic [31:0] y);
    if (!(o inside {DIV, DIVU, REM, REMU})) return 33;
    if (!DIV_EN || y == 32'd0) return 1;
    if ((o == DIV || o == REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] dv(input logic [31:0] x);
    return DIV_EN ? x : 32'hFFFF_FFFF;
  endfunction

  function automatic int dl();
    return DIV_EN ? 33 : 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_miss++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      $error("[TB] %s check did not hold", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startOp(input op_e o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input op_e o, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] exp_r, input int exp_l);
    exp_q.push_back(exp_r);
    lat_q.push_back(exp_l);
    startOp(o, x, y);
  endtask

  // Called in some cycle of an operation; returns in the done cycle (or at
  // the timeout) and checks latency, result and that busy never dropped.
  task automatic waitDone(input string tag, input int first_cyc);
    int cyc;
    int busy_low;
    logic [31:0] exp_r;
    int exp_l;
    cyc = first_cyc;
    busy_low = 0;
    while (!done && cyc < 45) begin
      if (!busy) busy_low++;
      step();
      cyc++;
    end
    if (!busy) busy_low++;
    exp_r = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    checkOutput({tag, " latency"}, 64'(cyc), 64'(exp_l));
    checkOutput({tag, " result"}, {32'b0, result}, {32'b0, exp_r});
    checkOutput({tag, " busy gap"}, 64'(busy_low), 64'd0);
    last_result = exp_r;
  endtask

  task automatic runOp(input string tag, input op_e o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_r, input int exp_l);
    applyStimulus(o, x, y, exp_r, exp_l);
    waitDone(tag, 1);
    step();
  endtask

  task automatic countDones(input string tag);
    int dn;
    dn = 0;
    repeat (40) begin
      step();
      if (done) dn++;
    end
    checkOutput(tag, 64'(dn), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = MUL;
    a     = '0;
    b     = '0;
    last_result = '0;
    repeat (3) step();
    checkOutput("reset busy", {63'b0, busy}, 64'd0);
    checkOutput("reset done", {63'b0, done}, 64'd0);
    checkOutput("reset result", {32'b0, result}, 64'd0);
    rst_n = 1'b1;
    step();

    applyStimulus(MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    checkOutput("mul cycle1 busy", {63'b0, busy}, 64'd1);
    waitDone("mul 7*-3", 1);
    step();
    checkOutput("mul after busy", {63'b0, busy}, 64'd0);
    checkOutput("mul after done", {63'b0, done}, 64'd0);
    checkOutput("mul held result", {32'b0, result}, 64'hFFFF_FFEB);

    runOp("mulh min*min",   MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    runOp("mulhu min*min",  MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    runOp("mulhsu min*min", MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 33);
    runOp("div -7/2",   DIV,  32'hFFFF_FFF9, 32'd2, dv(32'hFFFF_FFFD), dl());
    runOp("rem -7%2",   REM,  32'hFFFF_FFF9, 32'd2, dv(32'hFFFF_FFFF), dl());
    runOp("divu 100/7", DIVU, 32'd100, 32'd7, dv(32'd14), dl());
    runOp("remu 100%7", REMU, 32'd100, 32'd7, dv(32'd2), dl());
    runOp("divu by 0",  DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("remu by 0",  REMU, 32'd100, 32'd0, dv(32'd100), 1);
    runOp("div ovf",    DIV,  32'h8000_0000, 32'hFFFF_FFFF, dv(32'h8000_0000), 1);
    runOp("rem ovf",    REM,  32'h8000_0000, 32'hFFFF_FFFF, dv(32'd0), 1);

    for (int i = 0; i < 8; i++) begin
      op_e ro;
      logic [31:0] ra, rb;
      ro = op_e'(i[2:0]);
      ra = $urandom;
      rb = (i == 6) ? 32'd0 : $urandom;
      runOp($sformatf("random op%0d", i), ro, ra, rb, ref_model(ro, ra, rb), ref_latency(ro, ra, rb));
    end

    // Flush in cycle 10 of a multiply.
    startOp(MUL, 32'h1234, 32'h5678);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush busy", {63'b0, busy}, 64'd0);
    checkOutput("flush done", {63'b0, done}, 64'd0);
    checkOutput("flush result", {32'b0, result}, {32'b0, last_result});
    countDones("flush no done");

    // Flush and start together: the start is dropped.
    op    = MUL;
    a     = 32'd3;
    b     = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flush+start busy", {63'b0, busy}, 64'd0);
    countDones("flush+start no done");
    checkOutput("flush+start result", {32'b0, result}, {32'b0, last_result});

    // Reset in cycle 5 of a multiply.
    startOp(MUL, 32'd9, 32'd9);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    checkOutput("midreset busy", {63'b0, busy}, 64'd0);
    checkOutput("midreset done", {63'b0, done}, 64'd0);
    checkOutput("midreset result", {32'b0, result}, 64'd0);
    rst_n = 1'b1;
    last_result = '0;
    step();

    // Back-to-back, plus a start while busy that must be ignored.
    applyStimulus(MUL, 32'd11, 32'd13, 32'd143, 33);
    waitDone("b2b first", 1);
    applyStimulus(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);
    checkOutput("b2b held", {32'b0, result}, 64'd143);
    repeat (3) step();
    op    = MULHU;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1234_5678;
    start = 1'b1;
    step();
    start = 1'b0;
    waitDone("b2b second", 5);
    step();
    checkOutput("b2b idle busy", {63'b0, busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
